if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
- Pipeline register between instruction fetch and decode in the 16-bit CPU.
- Accepts each fetched instruction and its PC over a valid/ready handshake, then presents them with the instruction fields already split out.
- Its raw immediate field and width flag drive the decode-stage sign extenders, which exist in 8-to-16 and 12-to-16 forms.
- A 2-entry skid buffer gives a registered in_ready and full throughput under backpressure; a flush input discards wrong-path instructions.

Parameters:
- DATA_W, 16: instruction and PC width.
- IMM_W, 12: raw immediate output width; the widest immediate in the ISA.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  fetch presents a valid instruction.
- in_ready  output  1  stage can accept; registered output.
- in_instr  input  DATA_W  fetched instruction word.
- in_pc  input  DATA_W  PC of in_instr.
- flush  input  1  discard all held instructions (branch taken or jump).
- out_valid  output  1  decode-side data valid.
- out_ready  input  1  decode accepts this cycle.
- out_instr  output  DATA_W  held instruction word.
- out_pc  output  DATA_W  held PC.
- out_opcode  output  4  instr[15:12].
- out_rd  output  4  instr[11:8].
- out_rs  output  4  instr[7:4].
- out_funct  output  4  instr[3:0].
- out_imm  output  IMM_W  raw immediate, zero-padded; see Behaviour.
- out_imm_is12  output  1  1 = out_imm is a 12-bit field, 0 = 8-bit field in out_imm[7:0].

Behaviour:
- Reset (rst=1 at posedge):
  - Both entry valids clear; out_valid=0, in_ready=1.
  - All data outputs are 0.
  - rst overrides flush and all transfers.
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_ready = !skid_valid, taken from a flop. It never depends combinationally on out_ready.
- Main entry drives the outputs. Skid entry holds one overflow instruction.
- Per cycle, with no flush:
  - Main empty, or main fires: main loads the input if one arrives (or the skid entry if skid is full), else main goes empty.
  - Main full, main not firing, input arrives: input goes to skid; in_ready=0 next cycle.
  - Skid full and main fires: skid moves to main; skid clears; in_ready=1 next cycle. If an input transfer occurs in the same cycle, that input loads into skid. This case cannot arise, since in_ready=0 while skid is full.
- Order is strictly FIFO. There is no drop and no duplication.
- Latency: 1 cycle from input transfer to out_valid when the stage is empty. Throughput is 1 per cycle with out_ready held high.
- Field decode is computed at load time and stored with the entry. Outputs are stable while out_valid && !out_ready.
- Immediate rules:
  - Opcode OP_JMP (4'hC) or OP_JAL (4'hD): out_imm = instr[11:0], out_imm_is12=1.
  - All other opcodes: out_imm = {4'b0, instr[7:0]}, out_imm_is12=0.
  - No sign extension occurs in this block.
- Flush (synchronous):
  - Both valids clear next cycle; in_ready=1 next cycle.
  - An input transfer in the flush cycle is discarded.
  - An output transfer in the flush cycle still completes as seen by decode, and decode qualifies it with flush.
- Data registers load only on transfer, which saves power. Their contents while invalid are don't-care, except after reset, when they are 0.

Decomposition:
- Package cpu_pkg holds:
  - OP_JMP and OP_JAL.
  - Field bit-position constants.
  - A struct for the decoded entry (instr, pc, opcode, rd, rs, funct, imm, imm_is12).
- Sub-module if_id_field_decode: combinational split of the instruction into fields, instantiated once on the input path.
- Skid control stays in the top module.

Test Plan:
1. Reset, then 16'hC801 at pc 16'h0010, out_ready=1. Next cycle: out_valid=1, out_opcode=4'hC, out_imm=12'h801, out_imm_is12=1, out_pc=16'h0010.
2. 16'h2A7F. Required: out_opcode=4'h2, out_rd=4'hA, out_rs=4'h7, out_funct=4'hF, out_imm=12'h07F, out_imm_is12=0.
3. Backpressure:
   - Stimulus: out_ready=0, stream 16'h1001, 16'h1002, 16'h1003.
   - Two are accepted; in_ready=0 from the cycle after the second.
   - 16'h1003 is held by fetch.
   - After out_ready=1, the outputs are 1001, 1002, 1003 on consecutive cycles, with in_ready=1 one cycle after the first output fires.
4. Flush with both entries full and in_valid=1: next cycle out_valid=0, in_ready=1, and the flushed 16'h1003 never appears.
5. rst=1 mid-stream with both entries full: next cycle out_valid=0, in_ready=1, and all outputs are 0. A fresh 16'hD0FF is then accepted, giving out_imm=12'h0FF and out_imm_is12=1.
6. Continuous stream of 8 instructions with out_ready=1: one output per cycle, in order, and in_ready never drops.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes with long immediates, instruction field
// positions and the decoded IF/ID entry layout.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int IMM_W  = 12;

    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [3:0] OP_JAL = 4'hD;

    localparam int OPC_HI   = 15;
    localparam int OPC_LO   = 12;
    localparam int RD_HI    = 11;
    localparam int RD_LO    = 8;
    localparam int RS_HI    = 7;
    localparam int RS_LO    = 4;
    localparam int FUNCT_HI = 3;
    localparam int FUNCT_LO = 0;
    localparam int IMM8_HI  = 7;
    localparam int IMM12_HI = 11;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] pc;
        logic [3:0]        opcode;
        logic [3:0]        rd;
        logic [3:0]        rs;
        logic [3:0]        funct;
        logic [IMM_W-1:0]  imm;
        logic              immIs12;
    } ifIdEntry_t;

    function automatic logic hasImm12(input logic [3:0] opcode);
        return (opcode == OP_JMP) || (opcode == OP_JAL);
    endfunction

endpackage

// File: rtl/if_id_field_decode.sv
// Combinational split of a fetched instruction into its decode fields;
// the result is stored alongside the raw word in the IF/ID entries.
module if_id_field_decode
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0] instr,
    input  logic [DATA_W-1:0] pc,
    output ifIdEntry_t        entry
);

    logic [3:0] opcode;

    assign opcode = instr[OPC_HI:OPC_LO];

    always_comb begin
        entry         = '0;
        entry.instr   = instr;
        entry.pc      = pc;
        entry.opcode  = opcode;
        entry.rd      = instr[RD_HI:RD_LO];
        entry.rs      = instr[RS_HI:RS_LO];
        entry.funct   = instr[FUNCT_HI:FUNCT_LO];
        entry.immIs12 = hasImm12(opcode);
        // Raw field only; the decode stage owns sign extension.
        if (entry.immIs12)
            entry.imm = instr[IMM12_HI:0];
        else
            entry.imm = {{(IMM_W-IMM8_HI-1){1'b0}}, instr[IMM8_HI:0]};
    end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register built as a 2-entry skid buffer: registered in_ready,
// full throughput under backpressure, synchronous flush of held instructions.
module if_id_stage
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [DATA_W-1:0] in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [DATA_W-1:0] out_pc,
    output logic [3:0]        out_opcode,
    output logic [3:0]        out_rd,
    output logic [3:0]        out_rs,
    output logic [3:0]        out_funct,
    output logic [IMM_W-1:0]  out_imm,
    output logic              out_imm_is12
);

    ifIdEntry_t inEntry;
    ifIdEntry_t mainEntry, skidEntry;
    logic       mainValid, skidValid, inReadyQ;
    logic       mainValidNxt, skidValidNxt;
    logic       loadMainFromIn, loadMainFromSkid, loadSkid;
    logic       inFire, outFire;

    if_id_field_decode uDecode (
        .instr (in_instr),
        .pc    (in_pc),
        .entry (inEntry)
    );

    assign inFire  = in_valid && inReadyQ;
    assign outFire = mainValid && out_ready;

    always_comb begin
        mainValidNxt     = mainValid;
        skidValidNxt     = skidValid;
        loadMainFromIn   = 1'b0;
        loadMainFromSkid = 1'b0;
        loadSkid         = 1'b0;
        if (flush) begin
            mainValidNxt = 1'b0;
            skidValidNxt = 1'b0;
        end else if (!mainValid || outFire) begin
            if (skidValid) begin
                loadMainFromSkid = 1'b1;
                mainValidNxt     = 1'b1;
                // Unreachable while in_ready tracks !skidValid, kept for safety.
                loadSkid         = inFire;
                skidValidNxt     = inFire;
            end else begin
                loadMainFromIn = inFire;
                mainValidNxt   = inFire;
            end
        end else if (inFire) begin
            loadSkid     = 1'b1;
            skidValidNxt = 1'b1;
        end
    end

    // Data registers load only on transfer; reset zeroes them so outputs read 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            mainValid <= 1'b0;
            skidValid <= 1'b0;
            inReadyQ  <= 1'b1;
            mainEntry <= '0;
            skidEntry <= '0;
        end else begin
            mainValid <= mainValidNxt;
            skidValid <= skidValidNxt;
            inReadyQ  <= !skidValidNxt;
            if (loadMainFromSkid)
                mainEntry <= skidEntry;
            else if (loadMainFromIn)
                mainEntry <= inEntry;
            if (loadSkid)
                skidEntry <= inEntry;
        end
    end

    assign in_ready     = inReadyQ;
    assign out_valid    = mainValid;
    assign out_instr    = mainEntry.instr;
    assign out_pc       = mainEntry.pc;
    assign out_opcode   = mainEntry.opcode;
    assign out_rd       = mainEntry.rd;
    assign out_rs       = mainEntry.rs;
    assign out_funct    = mainEntry.funct;
    assign out_imm      = mainEntry.imm;
    assign out_imm_is12 = mainEntry.immIs12;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: field split, backpressure, flush, reset, streaming.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [15:0] in_instr, in_pc, out_instr, out_pc;
    logic [3:0]  out_opcode, out_rd, out_rs, out_funct;
    logic [11:0] out_imm;
    logic        out_imm_is12;

    int errCnt = 0;
    int chkCnt = 0;

    always #5 clk = ~clk;

    if_id_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_opcode   (out_opcode),
        .out_rd       (out_rd),
        .out_rs       (out_rs),
        .out_funct    (out_funct),
        .out_imm      (out_imm),
        .out_imm_is12 (out_imm_is12)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc);
        in_valid = v;
        in_instr = ins;
        in_pc    = pc;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 16'h0, 16'h0);
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_instr", out_instr, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_imm", out_imm, 0);
        rst = 1'b0;

        // 1: long-immediate jump
        out_ready = 1'b1;
        drive(1'b1, 16'hC801, 16'h0010);
        tick();
        chk("t1_valid", out_valid, 1);
        chk("t1_opcode", out_opcode, 4'hC);
        chk("t1_imm", out_imm, 12'h801);
        chk("t1_is12", out_imm_is12, 1);
        chk("t1_pc", out_pc, 16'h0010);

        // 2: 8-bit immediate format
        drive(1'b1, 16'h2A7F, 16'h0012);
        tick();
        chk("t2_instr", out_instr, 16'h2A7F);
        chk("t2_opcode", out_opcode, 4'h2);
        chk("t2_rd", out_rd, 4'hA);
        chk("t2_rs", out_rs, 4'h7);
        chk("t2_funct", out_funct, 4'hF);
        chk("t2_imm", out_imm, 12'h07F);
        chk("t2_is12", out_imm_is12, 0);
        drive(1'b0, 16'h0, 16'h0);
        tick();
        chk("t2_drain", out_valid, 0);

        // 3: backpressure fills main then skid; third word is held by fetch
        out_ready = 1'b0;
        drive(1'b1, 16'h1001, 16'h0100);
        tick();
        chk("t3_rdy_a", in_ready, 1);
        chk("t3_main", out_instr, 16'h1001);
        drive(1'b1, 16'h1002, 16'h0102);
        tick();
        chk("t3_rdy_b", in_ready, 0);
        chk("t3_hold_a", out_instr, 16'h1001);
        drive(1'b1, 16'h1003, 16'h0104);
        tick();
        chk("t3_rdy_c", in_ready, 0);
        chk("t3_hold_b", out_instr, 16'h1001);
        out_ready = 1'b1;
        tick();
        chk("t3_out2", out_instr, 16'h1002);
        chk("t3_out2_pc", out_pc, 16'h0102);
        chk("t3_rdy_back", in_ready, 1);
        tick();
        chk("t3_out3", out_instr, 16'h1003);
        chk("t3_out3_v", out_valid, 1);
        drive(1'b0, 16'h0, 16'h0);
        tick();
        chk("t3_drain", out_valid, 0);

        // 4: flush with both entries full and fetch offering 1003
        out_ready = 1'b0;
        drive(1'b1, 16'h2001, 16'h0200);
        tick();
        drive(1'b1, 16'h2002, 16'h0202);
        tick();
        chk("t4_full", in_ready, 0);
        drive(1'b1, 16'h1003, 16'h0204);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 16'h0, 16'h0);
        chk("t4_valid", out_valid, 0);
        chk("t4_rdy", in_ready, 1);
        out_ready = 1'b1;
        tick();
        chk("t4_gone_a", out_valid, 0);
        tick();
        chk("t4_gone_b", out_valid, 0);

        // 4b: an input accepted in the flush cycle is discarded
        drive(1'b1, 16'h2005, 16'h0206);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 16'h0, 16'h0);
        chk("t4_in_drop", out_valid, 0);

        // 5: reset mid-stream with both entries full
        out_ready = 1'b0;
        drive(1'b1, 16'h3001, 16'h0300);
        tick();
        drive(1'b1, 16'h3002, 16'h0302);
        tick();
        chk("t5_full", in_ready, 0);
        rst = 1'b1;
        flush = 1'b1;
        tick();
        rst = 1'b0;
        flush = 1'b0;
        chk("t5_valid", out_valid, 0);
        chk("t5_rdy", in_ready, 1);
        chk("t5_instr", out_instr, 0);
        chk("t5_pc", out_pc, 0);
        chk("t5_opcode", out_opcode, 0);
        chk("t5_imm", out_imm, 0);
        chk("t5_is12", out_imm_is12, 0);
        out_ready = 1'b1;
        drive(1'b1, 16'hD0FF, 16'h0400);
        tick();
        chk("t5_new_v", out_valid, 1);
        chk("t5_new_op", out_opcode, 4'hD);
        chk("t5_new_imm", out_imm, 12'h0FF);
        chk("t5_new_is12", out_imm_is12, 1);

        // 6: back-to-back stream of 8
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'h4000 + 16'(i), 16'h0500 + 16'(2*i));
            tick();
            chk("t6_valid", out_valid, 1);
            chk("t6_instr", out_instr, 16'h4000 + 16'(i));
            chk("t6_pc", out_pc, 16'h0500 + 16'(2*i));
            chk("t6_rdy", in_ready, 1);
        end
        drive(1'b0, 16'h0, 16'h0);
        tick();
        chk("t6_drain", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
